// File: rtl/text_console_ctrl_if.sv
// Character input handshake for the text console controller.
// The master side offers a character; the slave side accepts it.
interface text_console_ctrl_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] attr;

    modport master (
        output char_in,
        output char_valid,
        output attr,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        input  attr,
        output char_ready
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Text-mode console controller: clears video RAM, then writes
// incoming characters at the cursor and handles CR/LF/BS.
module text_console_ctrl #(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter logic [15:0] FILL_WORD = 16'h0700
) (
    input  logic                       clk,
    input  logic                       rst,
    text_console_ctrl_if.slave         chr,
    input  logic                       clear_req,
    output logic                       busy,
    output logic [11:0]                vram_addr,
    output logic [15:0]                vram_data,
    output logic                       vram_we,
    output logic [6:0]                 cursor_col,
    output logic [4:0]                 cursor_row
);

    localparam logic [6:0]  COL_MAX = 7'(COLS - 1);
    localparam logic [4:0]  ROW_MAX = 5'(ROWS - 1);
    localparam logic [11:0] LAST    = 12'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        accept;
    logic        printable;
    logic        is_cr;
    logic        is_lf;
    logic        is_bs;
    logic        clr_done;
    logic [11:0] cur_addr;

    logic        we_nxt;
    logic [11:0] addr_nxt;
    logic [15:0] data_nxt;
    logic [6:0]  col_nxt;
    logic [4:0]  row_nxt;

    assign busy           = (state == S_CLEAR);
    assign chr.char_ready = (state == S_IDLE) && !clear_req;
    assign accept         = chr.char_valid && chr.char_ready;

    assign printable = (chr.char_in >= 8'h20) && (chr.char_in <= 8'h7E);
    assign is_cr     = (chr.char_in == 8'h0D);
    assign is_lf     = (chr.char_in == 8'h0A);
    assign is_bs     = (chr.char_in == 8'h08);

    assign cur_addr = 12'(cursor_row) * 12'(COLS) + 12'(cursor_col);

    // The clear sweep is tracked by the registered address itself
    assign clr_done = vram_we && (vram_addr == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_CLEAR: begin
                if (clr_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                end else if (accept &&
                             (printable || (is_bs && cursor_col != 7'd0))) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        we_nxt   = 1'b0;
        addr_nxt = vram_addr;
        data_nxt = vram_data;
        col_nxt  = cursor_col;
        row_nxt  = cursor_row;
        unique case (state)
            S_CLEAR: begin
                col_nxt = 7'd0;
                row_nxt = 5'd0;
                if (!clr_done) begin
                    we_nxt   = 1'b1;
                    addr_nxt = vram_we ? vram_addr + 12'd1 : 12'd0;
                    data_nxt = FILL_WORD;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        printable: begin
                            we_nxt   = 1'b1;
                            addr_nxt = cur_addr;
                            data_nxt = {chr.attr, chr.char_in};
                            if (cursor_col == COL_MAX) begin
                                col_nxt = 7'd0;
                                row_nxt = (cursor_row == ROW_MAX) ?
                                          5'd0 : cursor_row + 5'd1;
                            end else begin
                                col_nxt = cursor_col + 7'd1;
                            end
                        end
                        is_cr: col_nxt = 7'd0;
                        is_lf: begin
                            col_nxt = 7'd0;
                            row_nxt = (cursor_row == ROW_MAX) ?
                                      5'd0 : cursor_row + 5'd1;
                        end
                        is_bs: begin
                            if (cursor_col != 7'd0) begin
                                we_nxt   = 1'b1;
                                addr_nxt = cur_addr - 12'd1;
                                data_nxt = FILL_WORD;
                                col_nxt  = cursor_col - 7'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_we    <= 1'b0;
            vram_addr  <= 12'd0;
            vram_data  <= 16'd0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
        end else begin
            vram_we    <= we_nxt;
            vram_addr  <= addr_nxt;
            vram_data  <= data_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: expected video RAM writes
// are queued by the stimulus and popped by a negedge monitor.
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        busy;
    logic [11:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_console_ctrl_if bus ();

    text_console_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .chr        (bus.slave),
        .clear_req  (clear_req),
        .busy       (busy),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .vram_we    (vram_we),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [27:0] sb[$];
    logic [27:0] mon_exp;
    int          mcol = 0;
    int          mrow = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && vram_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %h, expected none",
                         vram_addr, vram_data);
            end else begin
                mon_exp = sb.pop_front();
                chk("vram_write", {4'd0, vram_addr, vram_data}, {4'd0, mon_exp});
            end
        end
    end

    task automatic push_clear();
        for (int i = 0; i < 2000; i++) begin
            sb.push_back({12'(i), 16'h0700});
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        #1;
        while (bus.char_ready !== 1'b1 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (bus.char_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: char_ready %b after %0d cycles, expected 1",
                     name, bus.char_ready, budget);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        logic wr;
        wait_ready("send", 50);
        wr = 1'b0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            sb.push_back({12'(mrow * 80 + mcol), a, c});
            wr = 1'b1;
            if (mcol == 79) begin
                mcol = 0;
                mrow = (mrow == 24) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            mrow = (mrow + 1) % 25;
        end else if (c == 8'h08 && mcol > 0) begin
            mcol--;
            sb.push_back({12'(mrow * 80 + mcol), 16'h0700});
            wr = 1'b1;
        end
        bus.char_in    = c;
        bus.attr       = a;
        bus.char_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
        chk("write_strobe", {31'd0, vram_we}, {31'd0, wr});
        chk("cursor_col", {25'd0, cursor_col}, mcol);
        chk("cursor_row", {27'd0, cursor_row}, mrow);
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        chk({name, "_col"}, {25'd0, cursor_col}, col);
        chk({name, "_row"}, {27'd0, cursor_row}, row);
    endtask

    initial begin
        rst            = 1'b0;
        clear_req      = 1'b0;
        bus.char_in    = 8'h00;
        bus.attr       = 8'h00;
        bus.char_valid = 1'b0;
        #3;
        chk("rst_we", {31'd0, vram_we}, 0);
        chk("rst_addr", {20'd0, vram_addr}, 0);
        chk("rst_data", {16'd0, vram_data}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_ready", {31'd0, bus.char_ready}, 0);
        check_cursor("rst", 0, 0);

        push_clear();
        @(negedge clk);
        rst = 1'b1;
        wait_ready("init_clear", 2100);
        chk("init_clear_left", sb.size(), 0);
        chk("init_busy", {31'd0, busy}, 0);
        check_cursor("init_clear", 0, 0);

        send(8'h48, 8'h07);
        chk("h_addr", {20'd0, vram_addr}, 0);
        chk("h_data", {16'd0, vram_data}, 32'h0748);
        check_cursor("h", 1, 0);

        send(8'h01, 8'h07);
        check_cursor("discard", 1, 0);

        send(8'h0D, 8'h07);
        for (int i = 0; i < 24; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 79; i++) send(8'h78, 8'h07);
        check_cursor("pre_wrap", 79, 24);
        send(8'h41, 8'h1E);
        chk("wrap_addr", {20'd0, vram_addr}, 1999);
        chk("wrap_data", {16'd0, vram_data}, 32'h1E41);
        check_cursor("wrap", 0, 0);

        for (int i = 0; i < 3; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 5; i++) send(8'h2E, 8'h07);
        check_cursor("pre_bs", 5, 3);
        send(8'h08, 8'h07);
        chk("bs_addr", {20'd0, vram_addr}, 244);
        chk("bs_data", {16'd0, vram_data}, 32'h0700);
        check_cursor("bs", 4, 3);
        send(8'h0D, 8'h07);
        send(8'h08, 8'h07);
        chk("bs_col0_we", {31'd0, vram_we}, 0);
        check_cursor("bs_col0", 0, 3);

        for (int i = 0; i < 24; i++) send(8'h0A, 8'h07);
        for (int i = 0; i < 10; i++) send(8'h2D, 8'h07);
        check_cursor("pre_cr", 10, 2);
        send(8'h0D, 8'h07);
        check_cursor("cr", 0, 2);
        send(8'h0A, 8'h07);
        check_cursor("lf", 0, 3);
        for (int i = 0; i < 21; i++) send(8'h0A, 8'h07);
        check_cursor("pre_lf_wrap", 0, 24);
        send(8'h0A, 8'h07);
        check_cursor("lf_wrap", 0, 0);

        // Clear request and character in the same cycle: clear wins
        send(8'h2D, 8'h07);
        wait_ready("pre_clear", 50);
        clear_req      = 1'b1;
        bus.char_in    = 8'h5A;
        bus.attr       = 8'h07;
        bus.char_valid = 1'b1;
        #1;
        chk("clear_wins_ready", {31'd0, bus.char_ready}, 0);
        push_clear();
        @(posedge clk);
        #1;
        clear_req      = 1'b0;
        bus.char_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 1);
        mcol = 0;
        mrow = 0;
        repeat (300) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_ready("clear", 2100);
        chk("clear_left", sb.size(), 0);
        check_cursor("clear", 0, 0);

        send(8'h51, 8'h07);
        wait_ready("pre_rst_clear", 50);
        clear_req = 1'b1;
        push_clear();
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (500) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, vram_we}, 0);
        chk("mid_rst_addr", {20'd0, vram_addr}, 0);
        chk("mid_rst_data", {16'd0, vram_data}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 1);
        chk("mid_rst_ready", {31'd0, bus.char_ready}, 0);
        check_cursor("mid_rst", 0, 0);
        sb.delete();
        mcol = 0;
        mrow = 0;
        push_clear();
        @(negedge clk);
        rst = 1'b1;
        wait_ready("rst_clear", 2100);
        chk("rst_clear_left", sb.size(), 0);
        check_cursor("rst_clear", 0, 0);

        send(8'h48, 8'h07);
        chk("post_addr", {20'd0, vram_addr}, 0);
        chk("post_data", {16'd0, vram_data}, 32'h0748);
        repeat (3) @(negedge clk);
        chk("final_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 25, meaning text rows.
REQ-003 SHALL have parameter FILL_WORD, default 16'h0700, meaning the cell value written by clear and backspace.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port char_in  input  8  ASCII code to display.
REQ-007 SHALL have port char_valid  input  1  char_in valid.
REQ-008 SHALL have port char_ready  output  1  controller can accept a character this cycle.
REQ-009 SHALL have port attr  input  8  attribute byte, sampled with the accepted character.
REQ-010 SHALL have port clear_req  input  1  request full-screen clear.
REQ-011 SHALL have port busy  output  1  high while in CLEAR.
REQ-012 SHALL have port vram_addr  output  12  video RAM cell address, row*COLS+col.
REQ-013 SHALL have port vram_data  output  16  {attr, char} cell word.
REQ-014 SHALL have port vram_we  output  1  video RAM write strobe, one cell per high cycle.
REQ-015 SHALL have port cursor_col  output  7  current column.
REQ-016 SHALL have port cursor_row  output  5  current row.

Function
REQ-017 SHALL implement states CLEAR, IDLE, WRITE; all vram_* outputs registered.
REQ-018 CLEAR: SHALL write FILL_WORD to addresses 0..COLS*ROWS-1 (0..1999), one per cycle with vram_we=1, busy=1, char_ready=0; after the last address SHALL go to IDLE with cursor (0,0) and vram_we=0.
REQ-019 IDLE: char_ready=1; a character SHALL be accepted when char_valid && char_ready.
REQ-020 Printable 0x20..0x7E accepted in cycle N: SHALL present vram_we=1, vram_addr=row*COLS+col, vram_data={attr,char_in} in cycle N+1 (WRITE state, char_ready=0); char_ready=1 again in N+2.
REQ-021 After a printable write, cursor SHALL advance: col+1; at col=COLS-1 col=0 and row+1; at (COLS-1, ROWS-1) wrap to (0,0); no scrolling.
REQ-022 0x0D (CR): col=0, no write, stay IDLE, cursor updated in N+1.
REQ-023 0x0A (LF): col=0, row+1, row ROWS-1 wraps to 0, no write.
REQ-024 0x08 (BS): if col>0, col-1 and write FILL_WORD at the new position via WRITE; at col=0 no action.
REQ-025 Any other code SHALL be accepted and discarded, no write, cursor unchanged.
REQ-026 clear_req in IDLE SHALL enter CLEAR next cycle starting at address 0; if char_valid is high the same cycle, clear wins: char_ready SHALL be 0 that cycle and the character is not accepted.
REQ-027 clear_req in WRITE SHALL be honoured after the pending write completes; clear_req during CLEAR SHALL be ignored (no restart).
REQ-028 Address arithmetic SHALL be 12-bit unsigned; row*COLS SHALL not overflow for ROWS*COLS <= 4096.

Reset
REQ-029 rst low SHALL immediately force vram_we=0, vram_addr=0, vram_data=0, cursor (0,0), char_ready=0, busy=1, state CLEAR at address 0.
REQ-030 After rst deasserts, a full clear SHALL run before any character is accepted; reset mid-CLEAR or mid-WRITE restarts the clear from address 0.

Verification
REQ-031 Release reset -> exactly 2000 consecutive vram_we cycles, addresses 0..1999, data 16'h0700, then char_ready=1, cursor (0,0).
REQ-032 Send 'H' (0x48) with attr 0x07 at cursor (0,0) -> one write addr 0, data 16'h0748, one cycle after acceptance; cursor (1,0).
REQ-033 Cursor at (79,24), send 'A' -> write addr 1999 data {attr,0x41}; cursor wraps to (0,0).
REQ-034 Cursor at (5,3), send 0x08 -> write addr 244 data 16'h0700, cursor (4,3); at (0,3) send 0x08 -> no write, cursor unchanged.
REQ-035 Cursor (10,2): send 0x0D -> (0,2), no write; send 0x0A -> (0,3), no write; 0x0A at row 24 -> row 0.
REQ-036 Assert clear_req and char_valid in the same IDLE cycle -> char not accepted, busy=1 next cycle, full 2000-cell clear, cursor (0,0); pulse rst low mid-clear -> outputs zero immediately, clear restarts at 0.
